perm_stage_arb: RTL and testbench

Registered 2x2 arbitration stage of the BLESS permutation network. It compares the priority of two incoming flits and derives the `swap` control for the 2x2 permuter datapath. The higher-priority flit gets its productive output and the other is deflected. The result is latched into a one-cycle pipeline register that feeds the next permuter stage or the output latches.

---
 rtl/perm_stage_arb_pkg.sv | 13 +
 rtl/perm_priority_cmp.sv | 43 ++++
 rtl/perm_stage_arb.sv | 157 +++++++++++++++
 tb/tb_perm_stage_arb.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/perm_stage_arb_pkg.sv
// Shared defaults and productive-mask encodings for the BLESS 2x2 permuter.
// Used by perm_stage_arb and perm_priority_cmp.
package perm_stage_arb_pkg;

    localparam int AGE_W_D     = 8;
    localparam int ID_W_D      = 4;
    localparam int NUM_NODES_D = 16;
    localparam int EPOCH_LEN_D = 64;

    localparam logic [1:0] PROD_OUT0 = 2'b01;
    localparam logic [1:0] PROD_OUT1 = 2'b10;

endpackage

// File: rtl/perm_priority_cmp.sv
// Combinational winner select for the 2x2 arbitration stage.
// Golden flit beats age when GOLD_EN; equal age favours input 0.
module perm_priority_cmp
    import perm_stage_arb_pkg::*;
#(
    parameter int AGE_W   = AGE_W_D,
    parameter int ID_W    = ID_W_D,
    parameter bit GOLD_EN = 1'b0
) (
    input  logic [1:0]      i_valid,
    input  logic [AGE_W-1:0] i_age0,
    input  logic [AGE_W-1:0] i_age1,
    input  logic [ID_W-1:0]  i_src0,
    input  logic [ID_W-1:0]  i_src1,
    input  logic [ID_W-1:0]  i_gid,
    output logic            o_win
);

    logic [1:0] w_gold;

    always_comb begin
        w_gold = 2'b00;
        if (GOLD_EN) begin
            w_gold = {i_src1 == i_gid, i_src0 == i_gid};
        end
    end

    always_comb begin
        o_win = 1'b0;
        unique case (i_valid)
            2'b10: o_win = 1'b1;
            2'b11: begin
                if (w_gold[0] != w_gold[1]) begin
                    o_win = w_gold[1];
                end else begin
                    o_win = i_age1 > i_age0;
                end
            end
            default: o_win = 1'b0;
        endcase
    end

endmodule

// File: rtl/perm_stage_arb.sv
// Registered 2x2 arbitration stage of the BLESS permutation network.
// Optional golden-flit epoch priority enabled by `define GOLDEN_FLIT_EN.
module perm_stage_arb
    import perm_stage_arb_pkg::*;
#(
    parameter int FLIT_W    = 64,
    parameter int AGE_W     = AGE_W_D,
    parameter int ID_W      = ID_W_D,
    parameter int NUM_NODES = NUM_NODES_D,
    parameter int EPOCH_LEN = EPOCH_LEN_D
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        in_valid,
    input  logic [FLIT_W-1:0] in_flit0,
    input  logic [FLIT_W-1:0] in_flit1,
    input  logic [AGE_W-1:0]  in_age0,
    input  logic [AGE_W-1:0]  in_age1,
    input  logic [ID_W-1:0]   in_src0,
    input  logic [ID_W-1:0]   in_src1,
    input  logic [1:0]        in_prod0,
    input  logic [1:0]        in_prod1,
    output logic [1:0]        out_valid,
    output logic [FLIT_W-1:0] out_flit0,
    output logic [FLIT_W-1:0] out_flit1,
    output logic [AGE_W-1:0]  out_age0,
    output logic [AGE_W-1:0]  out_age1,
    output logic [ID_W-1:0]   out_src0,
    output logic [ID_W-1:0]   out_src1,
    output logic [1:0]        out_defl,
    output logic              swap_q
);

    logic [ID_W-1:0] w_gid;

`ifdef GOLDEN_FLIT_EN
    localparam bit GOLD_EN = 1'b1;
    localparam int EP_W = (EPOCH_LEN > 1) ? $clog2(EPOCH_LEN) : 1;
    localparam logic [EP_W-1:0] EP_LAST  = EP_W'(EPOCH_LEN - 1);
    localparam logic [ID_W-1:0] GID_LAST = ID_W'(NUM_NODES - 1);

    logic [EP_W-1:0] r_epoch;
    logic [ID_W-1:0] r_gid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_epoch <= '0;
            r_gid   <= '0;
        end else if (r_epoch == EP_LAST) begin
            r_epoch <= '0;
            r_gid   <= (r_gid == GID_LAST) ? '0 : r_gid + 1'b1;
        end else begin
            r_epoch <= r_epoch + 1'b1;
        end
    end

    assign w_gid = r_gid;
`else
    // Oldest-first only; epoch sizing parameters are inert here.
    localparam bit GOLD_EN = 1'b0 && (NUM_NODES > 0) && (EPOCH_LEN > 0);
    assign w_gid = '0;
`endif

    logic w_win;

    perm_priority_cmp #(
        .AGE_W   (AGE_W),
        .ID_W    (ID_W),
        .GOLD_EN (GOLD_EN)
    ) u_cmp (
        .i_valid (in_valid),
        .i_age0  (in_age0),
        .i_age1  (in_age1),
        .i_src0  (in_src0),
        .i_src1  (in_src1),
        .i_gid   (w_gid),
        .o_win   (w_win)
    );

    logic              w_swap;
    logic [1:0]        w_v;
    logic [1:0]        w_m0;
    logic [1:0]        w_m1;
    logic [1:0]        w_defl;
    logic [FLIT_W-1:0] w_f0;
    logic [FLIT_W-1:0] w_f1;
    logic [AGE_W-1:0]  w_a0;
    logic [AGE_W-1:0]  w_a1;
    logic [ID_W-1:0]   w_s0;
    logic [ID_W-1:0]   w_s1;
    logic [AGE_W-1:0]  w_na0;
    logic [AGE_W-1:0]  w_na1;

    assign w_swap = w_win ? (in_prod1 == PROD_OUT0)
                          : (in_prod0 == PROD_OUT1);

    assign w_v  = w_swap ? {in_valid[0], in_valid[1]} : in_valid;
    assign w_m0 = w_swap ? in_prod1 : in_prod0;
    assign w_m1 = w_swap ? in_prod0 : in_prod1;
    assign w_f0 = w_swap ? in_flit1 : in_flit0;
    assign w_f1 = w_swap ? in_flit0 : in_flit1;
    assign w_a0 = w_swap ? in_age1  : in_age0;
    assign w_a1 = w_swap ? in_age0  : in_age1;
    assign w_s0 = w_swap ? in_src1  : in_src0;
    assign w_s1 = w_swap ? in_src0  : in_src1;

    assign w_defl = {w_v[1] & ~w_m1[1], w_v[0] & ~w_m0[0]};

    // Deflection ages a flit, saturating so it never wraps to young.
    assign w_na0 = (w_defl[0] && (w_a0 != '1)) ? w_a0 + 1'b1 : w_a0;
    assign w_na1 = (w_defl[1] && (w_a1 != '1)) ? w_a1 + 1'b1 : w_a1;

    logic [1:0]        r_valid;
    logic [1:0]        r_defl;
    logic              r_swap;
    logic [FLIT_W-1:0] r_f0;
    logic [FLIT_W-1:0] r_f1;
    logic [AGE_W-1:0]  r_a0;
    logic [AGE_W-1:0]  r_a1;
    logic [ID_W-1:0]   r_s0;
    logic [ID_W-1:0]   r_s1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= '0;
            r_defl  <= '0;
            r_swap  <= 1'b0;
            r_f0    <= '0;
            r_f1    <= '0;
            r_a0    <= '0;
            r_a1    <= '0;
            r_s0    <= '0;
            r_s1    <= '0;
        end else begin
            r_valid <= w_v;
            r_defl  <= w_defl;
            r_swap  <= w_swap;
            r_f0    <= w_f0;
            r_f1    <= w_f1;
            r_a0    <= w_na0;
            r_a1    <= w_na1;
            r_s0    <= w_s0;
            r_s1    <= w_s1;
        end
    end

    assign out_valid = r_valid;
    assign out_defl  = r_defl;
    assign swap_q    = r_swap;
    assign out_flit0 = r_f0;
    assign out_flit1 = r_f1;
    assign out_age0  = r_a0;
    assign out_age1  = r_a1;
    assign out_src0  = r_s0;
    assign out_src1  = r_s1;

endmodule

// File: tb/tb_perm_stage_arb.sv
// Randomized bench for perm_stage_arb against a port-preference model.
// Honours `define GOLDEN_FLIT_EN for the golden-epoch expectations.
module tb_perm_stage_arb;

    localparam int FW  = 64;
    localparam int AW  = 8;
    localparam int IW  = 4;
    localparam int NN  = 16;
    localparam int EPL = 64;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [1:0]    in_valid = '0;
    logic [FW-1:0] in_flit0 = '0, in_flit1 = '0;
    logic [AW-1:0] in_age0 = '0, in_age1 = '0;
    logic [IW-1:0] in_src0 = '0, in_src1 = '0;
    logic [1:0]    in_prod0 = '0, in_prod1 = '0;
    logic [1:0]    out_valid, out_defl;
    logic [FW-1:0] out_flit0, out_flit1;
    logic [AW-1:0] out_age0, out_age1;
    logic [IW-1:0] out_src0, out_src1;
    logic          swap_q;

    perm_stage_arb dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid),
        .in_flit0(in_flit0), .in_flit1(in_flit1),
        .in_age0(in_age0), .in_age1(in_age1),
        .in_src0(in_src0), .in_src1(in_src1),
        .in_prod0(in_prod0), .in_prod1(in_prod1),
        .out_valid(out_valid), .out_flit0(out_flit0), .out_flit1(out_flit1),
        .out_age0(out_age0), .out_age1(out_age1),
        .out_src0(out_src0), .out_src1(out_src1),
        .out_defl(out_defl), .swap_q(swap_q)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int ep_cyc = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_defl",  64'(out_defl),  64'd0);
        check("rst_swap",  64'(swap_q),    64'd0);
        check("rst_flit0", out_flit0, 64'd0);
        check("rst_flit1", out_flit1, 64'd0);
        check("rst_age0",  64'(out_age0), 64'd0);
        check("rst_age1",  64'(out_age1), 64'd0);
        check("rst_src0",  64'(out_src0), 64'd0);
        check("rst_src1",  64'(out_src1), 64'd0);
    endtask

    // Drive one input set at the negedge, predict, then check after the edge.
    task automatic step(input logic [1:0] v,
                        input logic [FW-1:0] f0, input logic [FW-1:0] f1,
                        input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                        input logic [IW-1:0] s0, input logic [IW-1:0] s1,
                        input logic [1:0] p0, input logic [1:0] p1);
        logic [FW-1:0] f[2];
        logic [AW-1:0] a[2];
        logic [IW-1:0] s[2];
        logic [1:0]    p[2];
        int            gid, win, wport, j;
        bit            g0, g1;
        logic [1:0]    pm, ev, ed;
        logic [FW-1:0] ef[2];
        logic [AW-1:0] ea[2];
        logic [IW-1:0] es[2];
        f[0] = f0; f[1] = f1; a[0] = a0; a[1] = a1;
        s[0] = s0; s[1] = s1; p[0] = p0; p[1] = p1;
        in_valid = v; in_flit0 = f0; in_flit1 = f1;
        in_age0 = a0; in_age1 = a1; in_src0 = s0; in_src1 = s1;
        in_prod0 = p0; in_prod1 = p1;

        gid = (ep_cyc / EPL) % NN;
`ifdef GOLDEN_FLIT_EN
        g0 = (int'(s0) == gid);
        g1 = (int'(s1) == gid);
`else
        g0 = 1'b0;
        g1 = 1'b0;
`endif
        if (v == 2'b10)      win = 1;
        else if (v != 2'b11) win = 0;
        else if (g0 != g1)   win = g1 ? 1 : 0;
        else                 win = (a1 > a0) ? 1 : 0;

        pm = p[win];
        if (pm == 2'b01)      wport = 0;
        else if (pm == 2'b10) wport = 1;
        else                  wport = win;

        for (int k = 0; k < 2; k++) begin
            j = (k == wport) ? win : 1 - win;
            ev[k] = v[j];
            ed[k] = v[j] && !p[j][k];
            ef[k] = f[j];
            es[k] = s[j];
            ea[k] = (ed[k] && a[j] != 8'hFF) ? a[j] + 8'd1 : a[j];
        end

        @(posedge clk);
        ep_cyc++;
        #1;
        check("valid", 64'(out_valid), 64'(ev));
        check("defl",  64'(out_defl),  64'(ed));
        if (v != 2'b00)
            check("swap", 64'(swap_q), 64'(wport != win));
        if (ev[0]) begin
            check("flit0", out_flit0, ef[0]);
            check("age0",  64'(out_age0), 64'(ea[0]));
            check("src0",  64'(out_src0), 64'(es[0]));
        end
        if (ev[1]) begin
            check("flit1", out_flit1, ef[1]);
            check("age1",  64'(out_age1), 64'(ea[1]));
            check("src1",  64'(out_src1), 64'(es[1]));
        end
        @(negedge clk);
    endtask

    function automatic logic [AW-1:0] rand_age();
        case ($urandom_range(0, 3))
            0:       return 8'hFF;
            1:       return 8'($urandom_range(0, 3));
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        #1;
        check_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        ep_cyc  = 0;

        // age priority: older flit1 wins port 0, flit0 deflected
        step(2'b11, 64'hA0, 64'hA1, 8'd5, 8'd9, 4'd5, 4'd6, 2'b01, 2'b01);
        check("ap_swap", 64'(swap_q), 64'd1);
        check("ap_age1", 64'(out_age1), 64'd6);
        // tie-break: flit0 wins port 1
        step(2'b11, 64'hB0, 64'hB1, 8'd3, 8'd3, 4'd5, 4'd6, 2'b10, 2'b10);
        check("tb_defl", 64'(out_defl), 64'b01);
        // single flit, exact mask then both-productive
        step(2'b10, 64'hC0, 64'hC1, 8'd1, 8'd2, 4'd5, 4'd6, 2'b00, 2'b10);
        step(2'b10, 64'hD0, 64'hD1, 8'd1, 8'd2, 4'd5, 4'd6, 2'b00, 2'b11);
        // saturation of a deflected loser
        step(2'b11, 64'hE0, 64'hE1, 8'hFF, 8'hFF, 4'd5, 4'd6, 2'b01, 2'b01);
        check("sat_age1", 64'(out_age1), 64'hFF);
        step(2'b00, 64'h0, 64'h0, 8'd0, 8'd0, 4'd0, 4'd0, 2'b00, 2'b00);

        // async reset while both outputs valid
        step(2'b11, 64'hF0, 64'hF1, 8'd7, 8'd2, 4'd5, 4'd6, 2'b01, 2'b10);
        check("pre_rst_valid", 64'(out_valid), 64'b11);
        #1 reset_n = 1'b0;
        #1 check_reset();
        @(negedge clk);
        reset_n = 1'b1;
        ep_cyc  = 0;
        step(2'b01, 64'h11, 64'h12, 8'd4, 8'd0, 4'd5, 4'd6, 2'b01, 2'b00);

        // golden epoch: idle to epoch 1, then src1 age0 vs src2 age200
        while (ep_cyc < EPL)
            step(2'b00, 64'h0, 64'h0, 8'd0, 8'd0, 4'd0, 4'd0, 2'b00, 2'b00);
        step(2'b11, 64'h21, 64'h22, 8'd0, 8'd200, 4'd1, 4'd2, 2'b01, 2'b01);
`ifdef GOLDEN_FLIT_EN
        check("golden_win", 64'(out_src0), 64'd1);
`else
        check("oldest_win", 64'(out_src0), 64'd2);
`endif

        // random traffic across a full golden_id wrap
        for (int i = 0; i < NN * EPL + 200; i++) begin
            step(2'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                 rand_age(), rand_age(),
                 4'($urandom), 4'($urandom),
                 2'($urandom), 2'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
